// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: default line constants and
// the receiver FSM state encoding.
package uart_rx_pkg;

    localparam int DEFAULT_CLK_FREQ = 12_000_000;
    localparam int DEFAULT_BAUD     = 115_200;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_baudgen.sv
// Baud tick generator: while enabled, ticks once after half a bit period and
// then once per full bit period, so ticks land mid-bit after a start edge.
module baudgen
    import uart_rx_pkg::*;
#(
    parameter int clk_freq = DEFAULT_CLK_FREQ,
    parameter int baud     = DEFAULT_BAUD
) (
    input  logic clk,
    input  logic en,
    output logic baud_tick
);

    localparam int CLKS_PER_BIT = clk_freq / baud;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;
    logic             first;

    assign baud_tick = en && (cnt == (first ? HALF_LAST : FULL_LAST));

    // Dropping en clears the counter, so every frame starts from a clean phase.
    always_ff @(posedge clk) begin
        if (!en) begin
            cnt   <= '0;
            first <= 1'b1;
        end else if (baud_tick) begin
            cnt   <= '0;
            first <= 1'b0;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rx, samples mid-bit on baudgen ticks and
// emits one-cycle strobes for a good byte or a framing error.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int clk_freq = DEFAULT_CLK_FREQ,
    parameter int baud     = DEFAULT_BAUD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    rx_state_t  state, state_next;
    logic       sync_q1, rx_s;
    logic       baud_en, baud_tick;
    logic [7:0] shift, shift_next;
    logic [2:0] bit_idx, bit_idx_next;
    logic [7:0] rx_data_next;
    logic       rx_valid_next, frame_err_next;

    baudgen #(
        .clk_freq(clk_freq),
        .baud    (baud)
    ) u_baudgen (
        .clk      (clk),
        .en       (baud_en),
        .baud_tick(baud_tick)
    );

    assign baud_en = (state == START) || (state == DATA) || (state == STOP);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1   <= 1'b1;
            rx_s      <= 1'b1;
            state     <= IDLE;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sync_q1   <= rx;
            rx_s      <= sync_q1;
            state     <= state_next;
            rx_data   <= rx_data_next;
            rx_valid  <= rx_valid_next;
            frame_err <= frame_err_next;
        end
    end

    // Shift register and bit index are reloaded before use in every frame.
    always_ff @(posedge clk) begin
        shift   <= shift_next;
        bit_idx <= bit_idx_next;
    end

    always_comb begin
        state_next     = state;
        shift_next     = shift;
        bit_idx_next   = bit_idx;
        rx_data_next   = rx_data;
        rx_valid_next  = 1'b0;
        frame_err_next = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) state_next = START;
            end
            START: begin
                if (baud_tick) begin
                    if (rx_s) begin
                        state_next = IDLE;
                    end else begin
                        state_next   = DATA;
                        bit_idx_next = 3'd0;
                    end
                end
            end
            DATA: begin
                if (baud_tick) begin
                    shift_next   = {rx_s, shift[7:1]};
                    bit_idx_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_next = STOP;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (rx_s) begin
                        rx_data_next  = shift;
                        rx_valid_next = 1'b1;
                        state_next    = IDLE;
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // A held break reports once, then waits for the line to recover.
                if (rx_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames,
// checked against a frame-level event model.
module tb_uart_rx;

    localparam int CLK_FREQ = 12_000_000;
    localparam int BAUD     = 115_200;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int HALF     = CPB / 2;
    localparam int EXP_LAT  = 3 + HALF + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    always #5 clk = ~clk;

    uart_rx #(
        .clk_freq(CLK_FREQ),
        .baud    (BAUD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    typedef struct packed {
        logic        err;
        logic [7:0]  data;
        logic [31:0] cyc;
    } ev_t;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic [31:0] cyc = 0;
    logic [7:0]  last_good = 8'h00;
    ev_t         obs_q[$];
    ev_t         exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        ev_t ev;
        if (rst_n && (rx_valid || frame_err)) begin
            check("strobe_exclusive", {31'd0, rx_valid & frame_err}, 32'd0);
            ev.err  = frame_err;
            ev.data = rx_data;
            ev.cyc  = cyc;
            obs_q.push_back(ev);
        end
    end

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic expect_event(input logic err, input logic [7:0] data);
        ev_t e;
        e.err  = err;
        e.data = data;
        e.cyc  = cyc;
        exp_q.push_back(e);
        if (!err) last_good = data;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_ok);
        expect_event(!stop_ok, stop_ok ? b : 8'h00);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_ok);
    endtask

    task automatic compare_events(input string tag);
        int n;
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_kind"}, {31'd0, obs_q[i].err}, {31'd0, exp_q[i].err});
            if (!exp_q[i].err) check({tag, "_data"}, {24'd0, obs_q[i].data}, {24'd0, exp_q[i].data});
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [31:0] lat;
        logic [31:0] gap;
        logic        seen;
        logic [7:0]  b;
        logic        ok;

        repeat (5) @(negedge clk);
        check("reset_rx_data", {24'd0, rx_data}, 32'h00);
        check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        idle_bits(1);

        // Single frame, with latency from the start edge
        send_frame(8'h55, 1'b1);
        idle_bits(1);
        check("busy_after_0x55", {31'd0, busy}, 32'd0);
        lat = (obs_q.size() > 0) ? obs_q[0].cyc - exp_q[0].cyc : 32'd0;
        check("latency_0x55", {31'd0, (lat + 2 >= EXP_LAT) && (lat <= EXP_LAT + 2)}, 32'd1);
        compare_events("f55");
        check("rx_data_0x55", {24'd0, rx_data}, {24'd0, last_good});

        // Back-to-back frames with no idle gap
        send_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b1);
        idle_bits(1);
        gap = (obs_q.size() > 1) ? obs_q[1].cyc - obs_q[0].cyc : 32'd0;
        check("b2b_spacing", {31'd0, (gap + 1 >= 10 * CPB) && (gap <= 10 * CPB + 1)}, 32'd1);
        compare_events("b2b");
        check("rx_data_b2b", {24'd0, rx_data}, {24'd0, last_good});

        // Short low glitch is a false start
        rx = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        rx = 1'b1;
        check("glitch_busy_high", {31'd0, seen}, 32'd1);
        for (int i = 0; i < HALF + 20 && busy; i++) @(negedge clk);
        check("glitch_busy_low", {31'd0, busy}, 32'd0);
        idle_bits(1);
        compare_events("glitch");

        // Stop bit low, then a good frame
        send_frame(8'h81, 1'b0);
        idle_bits(2);
        check("rx_data_hold_ferr", {24'd0, rx_data}, {24'd0, last_good});
        compare_events("stop0");
        send_frame(8'h7E, 1'b1);
        idle_bits(1);
        compare_events("f7e");
        check("rx_data_0x7e", {24'd0, rx_data}, {24'd0, last_good});

        // Line break
        expect_event(1'b1, 8'h00);
        rx = 1'b0;
        repeat (30 * CPB) @(negedge clk);
        idle_bits(2);
        check("break_busy", {31'd0, busy}, 32'd0);
        compare_events("break");
        send_frame(8'h12, 1'b1);
        idle_bits(1);
        compare_events("f12");

        // Reset during data bit 3 of 0xFF
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        rx = 1'b1;
        repeat (HALF) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_rx_data", {24'd0, rx_data}, 32'h00);
        check("abort_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        last_good = 8'h00;
        rst_n = 1'b1;
        idle_bits(2);
        compare_events("abort");
        send_frame(8'h0F, 1'b1);
        idle_bits(1);
        compare_events("f0f");
        check("rx_data_0x0f", {24'd0, rx_data}, {24'd0, last_good});

        // Random frames, random gaps, occasional bad stop bit
        for (int k = 0; k < 20; k++) begin
            b  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 99) < 85);
            send_frame(b, ok);
            if (ok) idle_bits($urandom_range(0, 2));
            else    idle_bits($urandom_range(1, 2));
        end
        idle_bits(1);
        compare_events("rand");
        check("rx_data_rand", {24'd0, rx_data}, {24'd0, last_good});
        check("busy_end", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
